pad_power_sequencer: RTL and testbench

Power-mode sequencer that sits directly upstream of the pad controller. Accepts mode-change requests from the always-on power manager via a valid/ready handshake. Produces the registered `power_state`, `vdd_on` and `enter_active` signals the pad controller consumes, enforcing isolation-before-rail-off and ramp-before-release ordering.

---
 rtl/pad_pwr_pkg.sv | 19 +
 rtl/pad_pwr_timer.sv | 37 +++
 rtl/pad_power_sequencer.sv | 129 ++++++++++++
 tb/tb_pad_power_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pad_pwr_pkg.sv
// Shared power-mode encodings used by the sequencer and the pad controller.
// Power states and request modes share one 2-bit encoding space.
package pad_pwr_pkg;

  typedef enum logic [1:0] {
    PS_ACTIVE     = 2'b00,
    PS_SLEEP      = 2'b01,
    PS_DEEP_SLEEP = 2'b10,
    PS_DEEP_WAKE  = 2'b11
  } power_state_e;

  typedef enum logic [1:0] {
    MODE_ACTIVE  = 2'b00,
    MODE_SLEEP   = 2'b01,
    MODE_DEEP    = 2'b10,
    MODE_ILLEGAL = 2'b11
  } req_mode_e;

endpackage

// File: rtl/pad_pwr_timer.sv
// Loadable saturating up-counter; clear has priority over load.
module pad_pwr_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (count_q != {W{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pad_power_sequencer.sv
// Power-mode sequencer: isolation before rail-off, ramp before release.
module pad_power_sequencer
  import pad_pwr_pkg::*;
#(
  parameter int ISO_CYCLES      = 4,
  parameter int RAMP_MIN_CYCLES = 8,
  parameter int RAMP_TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  input  logic       vdd_good,
  output logic [1:0] power_state,
  output logic       vdd_on,
  output logic       enter_active,
  output logic       wake_fail
);

  localparam int CW = $clog2(RAMP_TIMEOUT + 1);
  localparam logic [CW-1:0] ISO_LAST  = CW'(ISO_CYCLES - 1);
  localparam logic [CW-1:0] RAMP_LAST = CW'(RAMP_MIN_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(RAMP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_ACTIVE,
    S_SLEEP,
    S_ISO,
    S_OFF,
    S_WAKE
  } state_e;

  state_e       state_q, state_d;
  power_state_e ps_q, ps_d;
  logic         vdd_q, vdd_d;
  logic         ea_q, ea_d;
  logic         wf_q, wf_d;
  logic         accept;
  logic [CW-1:0] count;

  pad_pwr_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_d != state_q),
    .load     (1'b0),
    .load_val ('0),
    .count    (count)
  );

  assign req_ready = (state_q == S_ACTIVE)
                  || (state_q == S_SLEEP)
                  || (state_q == S_OFF);
  assign accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACTIVE;
      ps_q    <= PS_ACTIVE;
      vdd_q   <= 1'b1;
      ea_q    <= 1'b0;
      wf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      vdd_q   <= vdd_d;
      ea_q    <= ea_d;
      wf_q    <= wf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ACTIVE: begin
        if (accept && req_mode == MODE_SLEEP) state_d = S_SLEEP;
        if (accept && req_mode == MODE_DEEP)  state_d = S_ISO;
      end
      S_SLEEP: begin
        if (accept && req_mode == MODE_ACTIVE) state_d = S_ACTIVE;
        if (accept && req_mode == MODE_DEEP)   state_d = S_ISO;
      end
      S_ISO: begin
        if (count >= ISO_LAST) state_d = S_OFF;
      end
      S_OFF: begin
        if (accept && req_mode == MODE_ACTIVE) state_d = S_WAKE;
      end
      S_WAKE: begin
        // Release wins over timeout when both land on the same cycle.
        if (count >= RAMP_LAST && vdd_good) begin
          state_d = S_ACTIVE;
        end else if (count >= TMO_LAST) begin
          state_d = S_OFF;
        end
      end
      default: state_d = S_ACTIVE;
    endcase
  end

  always_comb begin
    ps_d  = PS_ACTIVE;
    vdd_d = 1'b1;
    unique case (state_d)
      S_ACTIVE: ps_d = PS_ACTIVE;
      S_SLEEP:  ps_d = PS_SLEEP;
      S_ISO:    ps_d = PS_DEEP_SLEEP;
      S_OFF: begin
        ps_d  = PS_DEEP_SLEEP;
        vdd_d = 1'b0;
      end
      S_WAKE:   ps_d = PS_DEEP_WAKE;
      default:  ps_d = PS_ACTIVE;
    endcase
    ea_d = (state_d == S_ACTIVE) && (state_q != S_ACTIVE);
    wf_d = wf_q;
    if (accept) begin
      wf_d = 1'b0;
    end else if (state_q == S_WAKE && state_d == S_OFF) begin
      wf_d = 1'b1;
    end
  end

  assign power_state  = ps_q;
  assign vdd_on       = vdd_q;
  assign enter_active = ea_q;
  assign wake_fail    = wf_q;

endmodule

// File: tb/tb_pad_power_sequencer.sv
// Directed bench for pad_power_sequencer at default parameters.
module tb_pad_power_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_mode;
  logic       req_ready;
  logic       vdd_good;
  logic [1:0] power_state;
  logic       vdd_on;
  logic       enter_active;
  logic       wake_fail;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pad_power_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_mode     (req_mode),
    .req_ready    (req_ready),
    .vdd_good     (vdd_good),
    .power_state  (power_state),
    .vdd_on       (vdd_on),
    .enter_active (enter_active),
    .wake_fail    (wake_fail)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {power_state, vdd_on, req_ready, enter_active}
  task automatic st(input string tag, input logic [1:0] ps,
                    input logic vdd, input logic rdy, input logic ea);
    chk(tag, {3'b0, power_state, vdd_on, req_ready, enter_active},
        {3'b0, ps, vdd, rdy, ea});
  endtask

  task automatic req(input logic [1:0] m);
    req_valid = 1'b1;
    req_mode  = m;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_mode  = 2'b00;
    vdd_good  = 1'b1;
    tick();
    tick();
    st("reset", 2'b00, 1, 1, 0);
    chk("reset_wf", {7'b0, wake_fail}, 8'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    st("idle", 2'b00, 1, 1, 0);

    req(2'b01);
    st("sleep", 2'b01, 1, 1, 0);
    tick();
    st("sleep_hold", 2'b01, 1, 1, 0);
    req(2'b00);
    st("sleep_exit", 2'b00, 1, 1, 1);
    tick();
    st("pulse_end", 2'b00, 1, 1, 0);
    req(2'b11);
    st("illegal_active", 2'b00, 1, 1, 0);
    req(2'b00);
    st("same_active", 2'b00, 1, 1, 0);

    req(2'b10);
    req_valid = 1'b1;
    req_mode  = 2'b00;
    for (int i = 0; i < 4; i++) begin
      st($sformatf("iso_%0d", i), 2'b10, 1, 0, 0);
      tick();
    end
    req_valid = 1'b0;
    st("off", 2'b10, 0, 1, 0);
    req(2'b01);
    st("off_sleep_ign", 2'b10, 0, 1, 0);
    req(2'b11);
    st("off_illegal", 2'b10, 0, 1, 0);

    req(2'b00);
    req_valid = 1'b1;
    req_mode  = 2'b10;
    for (int i = 0; i < 8; i++) begin
      st($sformatf("wake_%0d", i), 2'b11, 1, 0, 0);
      tick();
    end
    req_valid = 1'b0;
    st("wake_done", 2'b00, 1, 1, 1);
    tick();
    st("wake_pulse_end", 2'b00, 1, 1, 0);

    vdd_good = 1'b0;
    req(2'b10);
    repeat (4) tick();
    st("tmo_off", 2'b10, 0, 1, 0);
    req(2'b00);
    repeat (63) tick();
    st("tmo_last", 2'b11, 1, 0, 0);
    chk("tmo_last_wf", {7'b0, wake_fail}, 8'h0);
    tick();
    st("tmo_fail", 2'b10, 0, 1, 0);
    chk("tmo_wf_set", {7'b0, wake_fail}, 8'h1);
    req(2'b01);
    chk("wf_clear", {7'b0, wake_fail}, 8'h0);
    st("wf_clear_st", 2'b10, 0, 1, 0);

    req(2'b00);
    repeat (10) tick();
    st("late_good_wait", 2'b11, 1, 0, 0);
    vdd_good = 1'b1;
    tick();
    st("late_good_exit", 2'b00, 1, 1, 1);

    req(2'b01);
    req(2'b10);
    st("sleep_to_iso", 2'b10, 1, 0, 0);
    repeat (4) tick();
    st("sleep_path_off", 2'b10, 0, 1, 0);

    vdd_good = 1'b0;
    req(2'b00);
    repeat (3) tick();
    st("pre_rst_wake", 2'b11, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    st("async_rst", 2'b00, 1, 1, 0);
    chk("async_rst_wf", {7'b0, wake_fail}, 8'h0);
    tick();
    rst_n = 1'b1;
    vdd_good = 1'b1;
    tick();
    st("post_rst", 2'b00, 1, 1, 0);
    tick();
    st("post_rst2", 2'b00, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
